// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: read ports, write port, clear request and status.
// The master side drives addresses/strobes; the slave side is the register file.
interface regfile_param_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              init_req;
   logic              busy;
   logic [ADDR_W-1:0] rd_addr1;
   logic [DATA_W-1:0] rd_data1;
   logic [ADDR_W-1:0] rd_addr2;
   logic [DATA_W-1:0] rd_data2;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_drop;

   modport master (
      output init_req, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
      input  busy, rd_data1, rd_data2, wr_drop
   );

   modport slave (
      input  init_req, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
      output busy, rd_data1, rd_data2, wr_drop
   );
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2R/1W register file with optional $zero entry and a hardware clear sequencer.
// Define REGFILE_BYPASS_EN to forward an accepted write straight to matching read ports.
module regfile_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32,
   parameter int ZERO_REG = 1
) (
   input logic             clk,
   input logic             rst_n,
   regfile_param_if.slave  rf
);

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   localparam bit                HasZero = (ZERO_REG != 0);
   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

   state_t            state, stateNext;
   logic [ADDR_W-1:0] clrCnt, clrCntNext;
   logic [DATA_W-1:0] mem [NUM_REGS];
   logic              busy;
   logic              wrZeroHit;
   logic              wrAccept;
   logic              wrDropNext;
   logic              wrDrop;

   function automatic logic inRange(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < (ADDR_W + 1)'(NUM_REGS);
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= CLEAR;
         clrCnt <= '0;
      end else begin
         state  <= stateNext;
         clrCnt <= clrCntNext;
      end
   end

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      stateNext  = state;
      clrCntNext = clrCnt;
      unique case (state)
         CLEAR: begin
            clrCntNext = clrCnt + 1'b1;
            if (clrCnt == LastIdx) begin
               stateNext  = IDLE;
               clrCntNext = '0;
            end
         end
         IDLE: begin
            if (rf.init_req) begin
               stateNext  = CLEAR;
               clrCntNext = '0;
            end
         end
      endcase
   end

   assign busy    = (state == CLEAR);
   assign rf.busy = busy;

   // Writes to $zero are swallowed quietly; every other rejected write is flagged.
   assign wrZeroHit  = HasZero && (rf.wr_addr == '0);
   assign wrAccept   = rf.wr_en && !busy && inRange(rf.wr_addr) && !wrZeroHit;
   assign wrDropNext = rf.wr_en && !wrAccept && !wrZeroHit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrDrop <= 1'b0;
      end else begin
         wrDrop <= wrDropNext;
      end
   end

   assign rf.wr_drop = wrDrop;

   // NOTE: the array has no reset; the clear sequencer zeroes it, which keeps it mappable to RAM.
   always_ff @(posedge clk) begin
      if (busy) begin
         mem[clrCnt] <= '0;
      end else if (wrAccept) begin
         mem[rf.wr_addr] <= rf.wr_data;
      end
   end

   function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] d;
      d = '0;
      if (!busy && inRange(a) && !(HasZero && a == '0)) begin
         d = mem[a];
`ifdef REGFILE_BYPASS_EN
         if (wrAccept && a == rf.wr_addr) begin
            d = rf.wr_data;
         end
`endif
      end
      return d;
   endfunction

   always_comb begin
      rf.rd_data1 = readPort(rf.rd_addr1);
      rf.rd_data2 = readPort(rf.rd_addr2);
   end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a 32-entry ($zero) and a 24-entry (plain r0) instance share one
// stimulus stream and are compared every cycle against an array-based model of the register file.
module tb_regfile_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        initReq;
   logic [4:0]  rdAddr1, rdAddr2, wrAddr;
   logic        wrEn;
   logic [31:0] wrData;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   regfile_param_if #(.DATA_W(32), .ADDR_W(5)) bus32 ();
   regfile_param_if #(.DATA_W(32), .ADDR_W(5)) bus24 ();

   assign bus32.init_req = initReq;
   assign bus32.rd_addr1 = rdAddr1;
   assign bus32.rd_addr2 = rdAddr2;
   assign bus32.wr_en    = wrEn;
   assign bus32.wr_addr  = wrAddr;
   assign bus32.wr_data  = wrData;
   assign bus24.init_req = initReq;
   assign bus24.rd_addr1 = rdAddr1;
   assign bus24.rd_addr2 = rdAddr2;
   assign bus24.wr_en    = wrEn;
   assign bus24.wr_addr  = wrAddr;
   assign bus24.wr_data  = wrData;

   regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .ZERO_REG(1)) dut32 (
      .clk(clk), .rst_n(rst_n), .rf(bus32)
   );
   regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(24), .ZERO_REG(0)) dut24 (
      .clk(clk), .rst_n(rst_n), .rf(bus24)
   );

`ifdef REGFILE_BYPASS_EN
   localparam logic [31:0] SameCycleR7 = 32'hA5A5A5A5;
`else
   localparam logic [31:0] SameCycleR7 = 32'h0000_0011;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: contents per instance, plus how many more clocks the clear keeps the file busy.
   localparam int NR [2] = '{32, 24};
   localparam int ZR [2] = '{1, 0};
   logic [31:0] mMem [2][32];
   int          mLeft [2];
   bit          mDrop [2];

   function automatic bit mBusy(input int k);
      return !rst_n || mLeft[k] > 0;
   endfunction

   function automatic bit mZero(input int k, input logic [4:0] a);
      return ZR[k] != 0 && a == 5'd0;
   endfunction

   function automatic bit mAccept(input int k);
      return wrEn && !mBusy(k) && int'(wrAddr) < NR[k] && !mZero(k, wrAddr);
   endfunction

   function automatic logic [31:0] mRead(input int k, input logic [4:0] a);
      if (mBusy(k) || int'(a) >= NR[k] || mZero(k, a)) return 32'd0;
`ifdef REGFILE_BYPASS_EN
      if (mAccept(k) && a == wrAddr) return wrData;
`endif
      return mMem[k][a];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            mLeft[k] = NR[k];
            mDrop[k] = 1'b0;
            for (int i = 0; i < 32; i++) mMem[k][i] = '0;
         end else begin
            mDrop[k] = wrEn && !mAccept(k) && !mZero(k, wrAddr);
            if (mAccept(k)) mMem[k][wrAddr] = wrData;
            if (mLeft[k] > 0) begin
               mLeft[k]--;
            end else if (initReq) begin
               mLeft[k] = NR[k];
               for (int i = 0; i < 32; i++) mMem[k][i] = '0;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("busy32", 32'(bus32.busy),    32'(mBusy(0)));
      check("drop32", 32'(bus32.wr_drop), 32'(mDrop[0]));
      check("rd1_32", bus32.rd_data1,     mRead(0, rdAddr1));
      check("rd2_32", bus32.rd_data2,     mRead(0, rdAddr2));
      check("busy24", 32'(bus24.busy),    32'(mBusy(1)));
      check("drop24", 32'(bus24.wr_drop), 32'(mDrop[1]));
      check("rd1_24", bus24.rd_data1,     mRead(1, rdAddr1));
      check("rd2_24", bus24.rd_data2,     mRead(1, rdAddr2));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts clocks until busy falls on each instance; pokeAt>0 injects a write and a second
   // init_req at that clock to show neither disturbs the running clear.
   task automatic measureBusy(input string tag, input int pokeAt);
      int n0, n1;
      bit d0, d1;
      n0 = 0; n1 = 0; d0 = 0; d1 = 0;
      for (int c = 1; c <= 200 && !(d0 && d1); c++) begin
         if (c == pokeAt) begin
            wrEn = 1'b1; wrAddr = 5'd9; wrData = 32'hBAD0BAD0; initReq = 1'b1;
         end
         step();
         if (c == pokeAt) begin
            wrEn = 1'b0; initReq = 1'b0;
            check({tag, " busy-write drop32"}, 32'(bus32.wr_drop), 32'd1);
            check({tag, " busy-write drop24"}, 32'(bus24.wr_drop), 32'd1);
         end
         if (!d0 && !bus32.busy) begin d0 = 1; n0 = c; end
         if (!d1 && !bus24.busy) begin d1 = 1; n1 = c; end
      end
      check({tag, " busy clks 32"}, 32'(n0), 32'd32);
      check({tag, " busy clks 24"}, 32'(n1), 32'd24);
   endtask

   task automatic sweepZero(input string tag);
      for (int a = 0; a < 32; a++) begin
         rdAddr1 = a[4:0];
         rdAddr2 = 5'(31 - a);
         #2;
         check({tag, " zero32"}, bus32.rd_data1, 32'd0);
         check({tag, " zero24"}, bus24.rd_data2, 32'd0);
         step();
      end
   endtask

   task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
      wrEn = 1'b1; wrAddr = a; wrData = d;
      step();
      wrEn = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b1; initReq = 1'b0; wrEn = 1'b0;
      wrAddr = '0; wrData = '0; rdAddr1 = 5'd3; rdAddr2 = 5'd4;
      #1 rst_n = 1'b0;
      #1;
      check("reset busy", 32'(bus32.busy), 32'd1);
      check("reset drop", 32'(bus32.wr_drop), 32'd0);
      check("reset rd1", bus32.rd_data1, 32'd0);
      repeat (2) step();
      rst_n = 1'b1;
      measureBusy("release", 0);
      sweepZero("after reset");

      // Plain write then read-back on the next cycle.
      writeReg(5'd5, 32'hDEADBEEF);
      rdAddr1 = 5'd5;
      #2;
      check("r5 rd32", bus32.rd_data1, 32'hDEADBEEF);
      check("r5 rd24", bus24.rd_data1, 32'hDEADBEEF);
      check("r5 drop32", 32'(bus32.wr_drop), 32'd0);
      step();

      // r0 is hardwired on the 32-entry build and ordinary on the 24-entry one.
      writeReg(5'd0, 32'h0000_1234);
      rdAddr1 = 5'd0;
      #2;
      check("r0 rd32", bus32.rd_data1, 32'd0);
      check("r0 drop32", 32'(bus32.wr_drop), 32'd0);
      check("r0 rd24", bus24.rd_data1, 32'h0000_1234);
      step();

      // r30 exists only in the 32-entry build.
      writeReg(5'd30, 32'hCAFEF00D);
      rdAddr1 = 5'd30;
      #2;
      check("r30 drop24", 32'(bus24.wr_drop), 32'd1);
      check("r30 rd24", bus24.rd_data1, 32'd0);
      check("r30 rd32", bus32.rd_data1, 32'hCAFEF00D);
      check("r30 drop32", 32'(bus32.wr_drop), 32'd0);
      step();
      check("r30 drop24 one cycle", 32'(bus24.wr_drop), 32'd0);

      // Same-cycle read of an entry being written.
      writeReg(5'd7, 32'h0000_0011);
      wrEn = 1'b1; wrAddr = 5'd7; wrData = 32'hA5A5A5A5; rdAddr1 = 5'd7; rdAddr2 = 5'd7;
      #2;
      check("r7 same-cycle rd2", bus32.rd_data2, SameCycleR7);
      check("r7 same-cycle rd1", bus24.rd_data1, SameCycleR7);
      step();
      wrEn = 1'b0;
      #2;
      check("r7 after rd1", bus32.rd_data1, 32'hA5A5A5A5);
      check("r7 after rd2", bus32.rd_data2, 32'hA5A5A5A5);
      step();

      // Short table of writes; the per-cycle compare covers the reads.
      writeReg(5'd1, 32'h0000_0001);
      writeReg(5'd23, 32'h8000_0000);
      writeReg(5'd31, 32'hFFFF_FFFF);
      writeReg(5'd2, 32'h1357_9BDF);
      for (int i = 0; i < 8; i++) begin
         rdAddr1 = 5'(i * 4 + 1);
         rdAddr2 = 5'(31 - i * 4);
         step();
      end
      rdAddr1 = 5'd23;
      #2;
      check("r23 rd24", bus24.rd_data1, 32'h8000_0000);
      step();

      // Clear on request, with a dropped write and a second request mid-clear.
      initReq = 1'b1;
      step();
      initReq = 1'b0;
      measureBusy("init", 3);
      sweepZero("after init");

      // Reset asserted part-way through a clear.
      writeReg(5'd5, 32'h0BAD_F00D);
      initReq = 1'b1;
      step();
      initReq = 1'b0;
      repeat (9) step();
      writeReg(5'd4, 32'h4444_4444);
      check("pre-reset drop32", 32'(bus32.wr_drop), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid-clear reset busy", 32'(bus32.busy), 32'd1);
      check("mid-clear reset drop", 32'(bus32.wr_drop), 32'd0);
      check("mid-clear reset rd", bus32.rd_data1, 32'd0);
      repeat (2) step();
      rst_n = 1'b1;
      measureBusy("mid-clear reset", 0);
      sweepZero("after mid-clear reset");

      writeReg(5'd12, 32'h0C0C_0C0C);
      rdAddr2 = 5'd12;
      #2;
      check("r12 rd2", bus32.rd_data2, 32'h0C0C_0C0C);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
